// File: rtl/surf_pkg.sv
// Shared widths and state encoding for the SURF host loader.
package surf_pkg;

    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 64;
    localparam int RES_W   = 16;
    localparam int STATE_W = 3;

    // Loader FSM state encoding.
    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_LOAD_A = 3'd1;
    localparam logic [STATE_W-1:0] S_LOAD_B = 3'd2;
    localparam logic [STATE_W-1:0] S_FLUSH  = 3'd3;
    localparam logic [STATE_W-1:0] S_GO     = 3'd4;
    localparam logic [STATE_W-1:0] S_WAIT   = 3'd5;
    localparam logic [STATE_W-1:0] S_DONE   = 3'd6;
    localparam logic [STATE_W-1:0] S_ERR    = 3'd7;

    // A job is in flight in every state except the two resting ones.
    function automatic logic state_is_busy(input logic [STATE_W-1:0] s);
        return !((s == S_IDLE) || (s == S_ERR));
    endfunction

endpackage

// File: rtl/surf_watchdog.sv
// Cycle watchdog: clearable up-counter that saturates at TIMEOUT-1 and
// flags the terminal count.
module surf_watchdog #(
    parameter int TIMEOUT = 1048576
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up while enabled until terminal.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == LAST);

endmodule

// File: rtl/surf_host_loader.sv
// Host loader for the SURF CalcDeterminant core: streams N_WORDS words into
// SRAM A then N_WORDS into SRAM B over their shared port B, kicks the core
// with Go_t, and waits (under a watchdog) for Done_t to capture the result.
module surf_host_loader
    import surf_pkg::*;
#(
    parameter int N_WORDS = 1024,
    parameter int TIMEOUT = 1048576
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] In_Data,
    output logic [ADDR_W-1:0] M_Addr,
    output logic [DATA_W-1:0] M_Di,
    output logic              MA_enb,
    output logic              MA_web,
    output logic              MB_enb,
    output logic              MB_web,
    output logic              Go_t,
    input  logic              Done_t,
    input  logic [RES_W-1:0]  Surf_Out_t,
    output logic              Busy,
    output logic [RES_W-1:0]  Result,
    output logic              Result_Valid,
    output logic              Err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

    logic [STATE_W-1:0] state_q,  state_d;
    logic [ADDR_W-1:0]  cnt_q,    cnt_d;
    logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
    logic [DATA_W-1:0]  m_di_q,   m_di_d;
    logic               ma_wr_q,  ma_wr_d;
    logic               mb_wr_q,  mb_wr_d;
    logic               go_q,     go_d;
    logic               rv_q,     rv_d;
    logic               err_q,    err_d;
    logic [RES_W-1:0]   result_q, result_d;

    logic in_ready;
    logic beat;
    logic wd_clr;
    logic wd_en;
    logic wd_tc;

    assign in_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign beat     = In_Valid && in_ready;

    surf_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk   (Clk),
        .rst_n (Rst_n),
        .clr   (wd_clr),
        .en    (wd_en),
        .tc    (wd_tc)
    );

    // Next-state, write-strobe and handshake decode for the loader FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_addr_d = m_addr_q;
        m_di_d   = m_di_q;
        ma_wr_d  = 1'b0;
        mb_wr_d  = 1'b0;
        go_d     = 1'b0;
        rv_d     = 1'b0;
        err_d    = err_q;
        result_d = result_q;
        wd_clr   = 1'b0;
        wd_en    = 1'b0;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (Start) begin
                    state_d = S_LOAD_A;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end

            S_LOAD_A, S_LOAD_B: begin
                if (beat) begin
                    // The beat is written one cycle later at the pre-increment address.
                    m_addr_d = cnt_q;
                    m_di_d   = In_Data;
                    ma_wr_d  = (state_q == S_LOAD_A);
                    mb_wr_d  = (state_q == S_LOAD_B);
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d   = '0;
                        state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_FLUSH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Final B write is on the bus this cycle; Go_t rises next cycle.
            S_FLUSH: begin
                state_d = S_GO;
                go_d    = 1'b1;
            end

            S_GO: begin
                state_d = S_WAIT;
                wd_clr  = 1'b1;
            end

            // Done_t wins over a watchdog expiry in the same cycle.
            S_WAIT: begin
                if (Done_t) begin
                    result_d = Surf_Out_t;
                    rv_d     = 1'b1;
                    state_d  = S_DONE;
                end else if (wd_tc) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    wd_en = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Loader registers; reset aborts any job and silences every strobe.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            m_addr_q <= '0;
            m_di_q   <= '0;
            ma_wr_q  <= 1'b0;
            mb_wr_q  <= 1'b0;
            go_q     <= 1'b0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_addr_q <= m_addr_d;
            m_di_q   <= m_di_d;
            ma_wr_q  <= ma_wr_d;
            mb_wr_q  <= mb_wr_d;
            go_q     <= go_d;
            rv_q     <= rv_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign In_Ready     = in_ready;
    assign M_Addr       = m_addr_q;
    assign M_Di         = m_di_q;
    assign MA_enb       = ma_wr_q;
    assign MA_web       = ma_wr_q;
    assign MB_enb       = mb_wr_q;
    assign MB_web       = mb_wr_q;
    assign Go_t         = go_q;
    assign Busy         = state_is_busy(state_q);
    assign Result       = result_q;
    assign Result_Valid = rv_q;
    assign Err          = err_q;

endmodule

// File: tb/tb_surf_host_loader.sv
// Self-checking bench for surf_host_loader (N_WORDS=4, TIMEOUT=16) with a
// transaction-level reference model of the expected SRAM writes and status.
module tb_surf_host_loader;

    localparam int NW = 4;
    localparam int TO = 16;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic        In_Valid = 1'b0;
    logic        In_Ready;
    logic [63:0] In_Data = '0;
    logic [14:0] M_Addr;
    logic [63:0] M_Di;
    logic        MA_enb, MA_web, MB_enb, MB_web;
    logic        Go_t;
    logic        Done_t = 1'b0;
    logic [15:0] Surf_Out_t = '0;
    logic        Busy;
    logic [15:0] Result;
    logic        Result_Valid;
    logic        Err;

    surf_host_loader #(
        .N_WORDS (NW),
        .TIMEOUT (TO)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Start        (Start),
        .In_Valid     (In_Valid),
        .In_Ready     (In_Ready),
        .In_Data      (In_Data),
        .M_Addr       (M_Addr),
        .M_Di         (M_Di),
        .MA_enb       (MA_enb),
        .MA_web       (MA_web),
        .MB_enb       (MB_enb),
        .MB_web       (MB_web),
        .Go_t         (Go_t),
        .Done_t       (Done_t),
        .Surf_Out_t   (Surf_Out_t),
        .Busy         (Busy),
        .Result       (Result),
        .Result_Valid (Result_Valid),
        .Err          (Err)
    );

    typedef struct packed {
        logic        sel;   // 0 = SRAM A, 1 = SRAM B
        logic [14:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         obs[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          go_count = 0;
    int          strobe_bad = 0;
    int          last_beat_cyc = 0;
    logic [63:0] w[2*NW];
    logic [15:0] last_result = '0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Passive monitor: log every write, count Go_t pulses, flag malformed strobes.
    always @(negedge Clk) begin
        if (Rst_n) begin
            if ((MA_enb !== MA_web) || (MB_enb !== MB_web) || (MA_enb && MB_enb))
                strobe_bad++;
            if (MA_enb || MB_enb)
                obs.push_back('{sel: MB_enb, addr: M_Addr, data: M_Di});
            if (Go_t)
                go_count++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outs();
        check("rst_in_ready", 64'(In_Ready), 64'd0);
        check("rst_go",       64'(Go_t), 64'd0);
        check("rst_busy",     64'(Busy), 64'd0);
        check("rst_rv",       64'(Result_Valid), 64'd0);
        check("rst_err",      64'(Err), 64'd0);
        check("rst_strobes",  64'({MA_enb, MA_web, MB_enb, MB_web}), 64'd0);
        check("rst_addr",     64'(M_Addr), 64'd0);
        check("rst_di",       M_Di, 64'd0);
        check("rst_result",   64'(Result), 64'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 2*NW; i++) w[i] = {$urandom, $urandom};
    endtask

    // Pulse Start; leaves the bench aligned at posedge+1.
    task automatic start_job();
        @(posedge Clk); #1;
        obs.delete();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    // mode 0: every cycle, 1: every other cycle, 2: random valid.
    // inject: pulse Start in LOAD_B and Done_t in LOAD_A (both must be ignored).
    task automatic drive_load(input int mode, input bit inject, input int max_beats);
        int idx = 0;
        int guard = 0;
        bit tog = 1'b1;
        bit s_done = 1'b0;
        bit d_done = 1'b0;
        bit v;
        while (idx < max_beats && guard < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            In_Valid   = v;
            In_Data    = v ? w[idx] : {$urandom, $urandom};
            Start      = inject && (idx >= NW + 1) && !s_done;
            if (Start) s_done = 1'b1;
            Done_t     = inject && (idx == 1) && !d_done;
            if (Done_t) d_done = 1'b1;
            Surf_Out_t = 16'hDEAD;
            @(negedge Clk);
            if (In_Valid && In_Ready) begin
                idx++;
                last_beat_cyc = cyc;
            end
            guard++;
            @(posedge Clk); #1;
        end
        In_Valid = 1'b0;
        Start    = 1'b0;
        Done_t   = 1'b0;
        check("load_beats", 64'(idx), 64'(max_beats));
    endtask

    // Reference: word i goes to A[i] for i < NW, else to B[i-NW], in order.
    task automatic check_writes(input int n);
        wr_t e;
        check("wr_count", 64'(obs.size()), 64'(n));
        for (int i = 0; i < n && i < obs.size(); i++) begin
            e.sel  = (i >= NW);
            e.addr = 15'(i % NW);
            e.data = w[i];
            check("wr_sel",  64'(obs[i].sel),  64'(e.sel));
            check("wr_addr", 64'(obs[i].addr), 64'(e.addr));
            check("wr_data", obs[i].data, e.data);
        end
    endtask

    task automatic wait_go();
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge Clk);
            if (Go_t) seen = 1'b1;
        end
        check("go_seen", 64'(seen), 64'd1);
        check("go_latency", 64'(cyc - last_beat_cyc), 64'd2);
    endtask

    // k = WAIT-relative cycle in which Done_t is driven (0 = never).
    task automatic do_wait(input int k, input logic [15:0] val);
        bit          accepted;
        logic [15:0] prev;
        logic [15:0] exp_res;
        accepted = (k >= 1) && (k <= TO);
        prev     = last_result;
        for (int c = 1; c <= TO + 4; c++) begin
            @(posedge Clk); #1;
            Done_t     = (c == k);
            Surf_Out_t = (c == k) ? val : 16'($urandom);
            @(negedge Clk);
            exp_res = (accepted && c > k) ? val : prev;
            check("wait_rv",     64'(Result_Valid), 64'(accepted && (c == k + 1)));
            check("wait_busy",   64'(Busy),         64'(accepted ? (c <= k + 1) : (c <= TO)));
            check("wait_err",    64'(Err),          64'(!accepted && (c >= TO + 1)));
            check("wait_result", 64'(Result),       64'(exp_res));
            check("wait_go_off", 64'(Go_t),         64'd0);
        end
        Done_t = 1'b0;
        if (accepted) last_result = val;
    endtask

    task automatic run_job(input int mode, input bit inject, input int k, input logic [15:0] val);
        int gc;
        gc = go_count;
        start_job();
        check("job_busy", 64'(Busy), 64'd1);
        check("job_err_clr", 64'(Err), 64'd0);
        drive_load(mode, inject, 2*NW);
        wait_go();
        do_wait(k, val);
        check("go_once", 64'(go_count - gc), 64'd1);
        check_writes(2*NW);
    endtask

    initial begin
        int gc;
        #12;
        check_reset_outs();
        @(negedge Clk);
        Rst_n = 1'b1;

        // Back-to-back beats 0x10..0x17, Done_t 5 cycles after Go_t.
        for (int i = 0; i < 2*NW; i++) w[i] = 64'(8'h10 + i);
        run_job(0, 1'b0, 5, 16'hBEEF);

        // In_Valid toggling every other cycle.
        fill_random();
        run_job(1, 1'b0, int'($urandom_range(1, TO)), 16'($urandom));

        // Random valid, with stray Start in LOAD_B and Done_t in LOAD_A.
        fill_random();
        run_job(2, 1'b1, int'($urandom_range(1, TO)), 16'($urandom));

        // Done_t never returns: watchdog expiry, Result must hold.
        fill_random();
        run_job(int'($urandom_range(0, 2)), 1'b0, 0, 16'h0);

        // New Start out of ERR; Done_t on the last allowed WAIT cycle.
        fill_random();
        run_job(int'($urandom_range(0, 2)), 1'b0, TO, 16'($urandom));

        // Reset after the 3rd B beat.
        fill_random();
        start_job();
        drive_load(0, 1'b0, NW + 3);
        #1;
        Rst_n = 1'b0;
        #1;
        check_reset_outs();
        check_writes(NW + 2);
        last_result = '0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        gc = go_count;
        repeat (30) @(negedge Clk);
        check("rst_no_go", 64'(go_count - gc), 64'd0);
        check("rst_no_wr", 64'(obs.size()), 64'(NW + 2));
        check("rst_idle_busy", 64'(Busy), 64'd0);

        // Recovery after reset.
        fill_random();
        run_job(2, 1'b0, 1, 16'($urandom));

        check("strobe_protocol", 64'(strobe_bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/surf_host_loader.md
SURF_HOST_LOADER -- requirements
Module: surf_host_loader

Interface
REQ-001 SHALL have parameter N_WORDS, default 1024, giving the 64-bit words loaded into each SRAM per job (2..32768).
REQ-002 SHALL have parameter TIMEOUT, default 1048576, giving the maximum cycles to wait for Done_t after Go_t.
REQ-003 SHALL have port Clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port Rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port Start, input, 1: one-cycle job request.
REQ-006 SHALL have port In_Valid, input, 1, and port In_Ready, output, 1: the input stream handshake.
REQ-007 SHALL have port In_Data, input, 64: the stream word.
REQ-008 SHALL have port M_Addr, output, 15, and port M_Di, output, 64: the shared port-B address and write data for both SRAMs.
REQ-009 SHALL have ports MA_enb, MA_web, MB_enb and MB_web, output, 1 each: the port-B enables and write enables of SRAM A and SRAM B.
REQ-010 SHALL have port Go_t, output, 1, port Done_t, input, 1, and port Surf_Out_t, input, 16: the CalcDeterminant core handshake.
REQ-011 SHALL have port Busy, output, 1, port Result, output, 16, port Result_Valid, output, 1, and port Err, output, 1: the status and result outputs.

Function
REQ-012 SHALL implement states IDLE, LOAD_A, LOAD_B, FLUSH, GO, WAIT, DONE and ERR.
REQ-013 SHALL go from IDLE or ERR to LOAD_A on Start, clear the word counter and clear Err; Start SHALL be ignored in all other states.
REQ-014 SHALL drive In_Ready = 1 only in LOAD_A and LOAD_B; a beat is In_Valid & In_Ready.
REQ-015 SHALL register each beat accepted in cycle t and write it in cycle t+1: M_Addr = counter value at t, M_Di = In_Data at t, and enb = web = 1 on the selected SRAM only.
REQ-016 SHALL drive MA_enb, MA_web, MB_enb and MB_web to 0 in every cycle with no write; In_Valid low stalls the counter with no write issued.
REQ-017 SHALL increment the counter (15-bit) per beat; the beat with counter = N_WORDS-1 SHALL reset the counter to 0 and move LOAD_A to LOAD_B, or LOAD_B to FLUSH.
REQ-018 FLUSH SHALL last one cycle (the final B write), then go to GO.
REQ-019 GO SHALL assert Go_t for exactly one cycle, then go to WAIT with the watchdog cleared.
REQ-020 In WAIT, Done_t = 1 SHALL capture Surf_Out_t into Result and go to DONE; otherwise the watchdog SHALL increment.
REQ-021 A watchdog reaching TIMEOUT-1 without Done_t SHALL move WAIT to ERR with Err = 1 (sticky until the next Start).
REQ-022 DONE SHALL assert Result_Valid for exactly one cycle, then go to IDLE; Result SHALL hold until the next capture.
REQ-023 Done_t outside WAIT SHALL be ignored.
REQ-024 Busy SHALL be 1 in every state except IDLE and ERR.
REQ-025 Go_t, Result_Valid and all memory strobes SHALL be registered outputs.

Reset
REQ-026 Rst_n low SHALL asynchronously force IDLE, clear both counters, and set In_Ready, Go_t, Busy, Result_Valid, Err, MA_enb, MA_web, MB_enb and MB_web to 0, with M_Addr = 0, M_Di = 0 and Result = 0.
REQ-027 Rst_n asserted mid-load or mid-wait SHALL abort the job with no further write or Go_t; the SRAM contents are undefined.

Structure
REQ-028 The shared package surf_pkg SHALL hold the address width (15), data width (64), result width (16) and the state enumeration.
REQ-029 The watchdog SHALL be the sub-module surf_watchdog (clear, enable, terminal-count output, TIMEOUT parameter).

Verification (N_WORDS=4, TIMEOUT=16)
REQ-030 Start, then 8 back-to-back beats 0x10..0x17 -> A writes addr 0..3 with 0x10..0x13, B writes addr 0..3 with 0x14..0x17; Go_t pulses 2 cycles after the last beat.
REQ-031 In_Valid toggled every other cycle -> identical writes, no gaps in address, no duplicate strobes.
REQ-032 Done_t 5 cycles after Go_t with Surf_Out_t=0xBEEF -> Result=0xBEEF, Result_Valid high for 1 cycle, Busy=0 the next cycle.
REQ-033 Done_t never returns -> Err=1 after 16 WAIT cycles; a new Start clears Err and reloads from addr 0.
REQ-034 Rst_n low after the 3rd B beat -> all outputs at reset values immediately, no Go_t afterwards.
REQ-035 Start pulsed during LOAD_B, and Done_t pulsed during LOAD_A -> both ignored, sequence unchanged.
